rega_multizona: RTL and testbench

- Parametrised successor of the single-tank automatic irrigation controller.
- One tank serves ZONES irrigation zones, each with its own request and mode (drip/sprinkler).
- The block contains the tank fill/drain FSM, the level counter with a programmable tick rate, a round-robin zone arbiter, cleaning drain, error detection and fertilizer mixing.
- It sits between the board inputs (switches, button) and the display/matrix drivers, which consume nivel and the status flags.

---
 rtl/rega_multizona.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rega_multizona.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rega_multizona.sv
// Multi-zone irrigation controller: one tank feeding ZONES zones.
// Contains the fill/drain FSM, the tick-paced level counter, a round-robin
// zone arbiter, the cleaning drain, invalid-mode error handling and the
// fertilizer mixer that runs during sprinkler irrigation.
module rega_multizona #(
    parameter int LEVEL_W     = 3,
    parameter int ZONES       = 4,
    parameter int CLK_DIV     = 50000,
    parameter int FILL_TICKS  = 1,
    parameter int DRIP_TICKS  = 4,
    parameter int SPRAY_TICKS = 2,
    parameter int CLEAN_TICKS = 1,
    parameter int MIX_TICKS   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ZONES-1:0]     zone_req,
    input  logic [2*ZONES-1:0]   zone_mode,
    input  logic                 B_Adb,
    output logic                 Ve,
    output logic                 ERRO,
    output logic                 Gotejamento,
    output logic                 Aspersao,
    output logic                 Limpeza,
    output logic                 Mist_Adb,
    output logic [ZONES-1:0]     zone_active,
    output logic [LEVEL_W-1:0]   nivel,
    output logic                 busy
);

    function automatic int max_rate();
        int m;
        m = FILL_TICKS;
        if (DRIP_TICKS  > m) m = DRIP_TICKS;
        if (SPRAY_TICKS > m) m = SPRAY_TICKS;
        if (CLEAN_TICKS > m) m = CLEAN_TICKS;
        return m;
    endfunction

    localparam int PRE_W  = $clog2(CLK_DIV);
    localparam int STEP_W = $clog2(max_rate() + 1);
    localparam int MIX_W  = $clog2(MIX_TICKS + 1);
    localparam int IDX_W  = $clog2(ZONES);

    localparam logic [LEVEL_W-1:0] FULL     = '1;
    localparam logic [LEVEL_W-1:0] LAST     = FULL - 1'b1;
    localparam logic [LEVEL_W-1:0] ONE_LVL  = LEVEL_W'(1);
    localparam logic [ZONES-1:0]   ONE_ZONE = ZONES'(1);
    localparam logic [MIX_W-1:0]   MIX_LAST = MIX_W'(MIX_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE, FILL, READY, DRIP, SPRAY, CLEAN, ERR
    } state_t;

    // Level arithmetic saturates so the tank level can never wrap.
    function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] l);
        return (l == FULL) ? l : l + 1'b1;
    endfunction

    function automatic logic [LEVEL_W-1:0] level_dec(input logic [LEVEL_W-1:0] l);
        return (l == '0) ? l : l - 1'b1;
    endfunction

    state_t               state, state_nxt;
    logic [LEVEL_W-1:0]   nivel_nxt;
    logic [PRE_W-1:0]     presc;
    logic                 tick;
    logic [STEP_W-1:0]    step_cnt;
    logic [STEP_W-1:0]    rate_m1;
    logic                 step;
    logic [IDX_W-1:0]     rr_ptr, ptr_nxt;
    logic [IDX_W-1:0]     gnt_idx, gnt_nxt;
    logic                 arb_found;
    logic [IDX_W-1:0]     arb_idx;
    logic [1:0]           arb_mode;
    logic                 gnt_req;
    logic [1:0]           gnt_mode_now;
    logic                 empty;
    logic                 b_adb_p0, b_adb_p1, b_adb_p2;
    logic                 b_rise;
    logic                 adubou;
    logic [MIX_W-1:0]     mix_cnt;

    assign tick = (presc == PRE_W'(CLK_DIV - 1));

    // Free-running base-tick prescaler, independent of the FSM.
    always_ff @(posedge clk) begin
        if (reset)     presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // Ticks-per-step for the current state; idle states reuse the fill rate.
    always_comb begin
        rate_m1 = STEP_W'(FILL_TICKS - 1);
        case (state)
            DRIP:    rate_m1 = STEP_W'(DRIP_TICKS - 1);
            SPRAY:   rate_m1 = STEP_W'(SPRAY_TICKS - 1);
            CLEAN:   rate_m1 = STEP_W'(CLEAN_TICKS - 1);
            default: rate_m1 = STEP_W'(FILL_TICKS - 1);
        endcase
    end

    assign step = tick && (step_cnt == rate_m1);

    // Step counter restarts on every state change so each state gets full periods.
    always_ff @(posedge clk) begin
        if (reset)                  step_cnt <= '0;
        else if (state_nxt != state) step_cnt <= '0;
        else if (tick)              step_cnt <= step ? '0 : step_cnt + 1'b1;
    end

    // Round-robin search starting just after the last granted zone.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 1; i <= ZONES; i++) begin
            if (!arb_found && zone_req[(int'(rr_ptr) + i) % ZONES]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'((int'(rr_ptr) + i) % ZONES);
            end
        end
    end

    assign arb_mode     = zone_mode[{arb_idx, 1'b0} +: 2];
    assign gnt_req      = zone_req[gnt_idx];
    assign gnt_mode_now = zone_mode[{gnt_idx, 1'b0} +: 2];

    // Next-state, level and grant decisions.
    always_comb begin
        state_nxt = state;
        nivel_nxt = nivel;
        ptr_nxt   = rr_ptr;
        gnt_nxt   = gnt_idx;
        empty     = 1'b0;
        case (state)
            IDLE: state_nxt = FILL;
            FILL: begin
                if (nivel == FULL) begin
                    state_nxt = READY;
                end else if (step) begin
                    nivel_nxt = level_inc(nivel);
                    if (nivel == LAST) state_nxt = READY;
                end
            end
            READY: begin
                // A requesting zone with mode 00 blocks the grant; pointer stays put.
                if (arb_found && arb_mode != 2'b00) begin
                    ptr_nxt = arb_idx;
                    gnt_nxt = arb_idx;
                    case (arb_mode)
                        2'b01:   state_nxt = DRIP;
                        2'b10:   state_nxt = SPRAY;
                        default: state_nxt = ERR;
                    endcase
                end
            end
            DRIP, SPRAY: begin
                if (!gnt_req) begin
                    state_nxt = CLEAN;
                end else if (step) begin
                    nivel_nxt = level_dec(nivel);
                    if (nivel == ONE_LVL) begin
                        state_nxt = FILL;
                        empty     = 1'b1;
                    end
                end
            end
            CLEAN: begin
                if (nivel == '0) begin
                    state_nxt = FILL;
                    empty     = 1'b1;
                end else if (step) begin
                    nivel_nxt = level_dec(nivel);
                    if (nivel == ONE_LVL) begin
                        state_nxt = FILL;
                        empty     = 1'b1;
                    end
                end
            end
            ERR: begin
                if (!gnt_req || gnt_mode_now == 2'b01 || gnt_mode_now == 2'b10)
                    state_nxt = READY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, level, arbiter pointer and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            nivel       <= '0;
            rr_ptr      <= IDX_W'(ZONES - 1);
            gnt_idx     <= '0;
            Ve          <= 1'b0;
            ERRO        <= 1'b0;
            Gotejamento <= 1'b0;
            Aspersao    <= 1'b0;
            Limpeza     <= 1'b0;
            busy        <= 1'b0;
            zone_active <= '0;
        end else begin
            state       <= state_nxt;
            nivel       <= nivel_nxt;
            rr_ptr      <= ptr_nxt;
            gnt_idx     <= gnt_nxt;
            Ve          <= (state_nxt == FILL);
            ERRO        <= (state_nxt == ERR);
            Gotejamento <= (state_nxt == DRIP);
            Aspersao    <= (state_nxt == SPRAY);
            Limpeza     <= (state_nxt == CLEAN);
            busy        <= (state_nxt != READY);
            zone_active <= (state_nxt == DRIP || state_nxt == SPRAY || state_nxt == ERR)
                           ? (ONE_ZONE << gnt_nxt) : '0;
        end
    end

    assign b_rise = b_adb_p1 && !b_adb_p2;

    // Button synchroniser (two flops) plus one flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_adb_p0 <= 1'b0;
            b_adb_p1 <= 1'b0;
            b_adb_p2 <= 1'b0;
        end else begin
            b_adb_p0 <= B_Adb;
            b_adb_p1 <= b_adb_p0;
            b_adb_p2 <= b_adb_p1;
        end
    end

    // Fertilizer mixer: one dose per tank, only while sprinkling.
    always_ff @(posedge clk) begin
        if (reset) begin
            adubou   <= 1'b0;
            Mist_Adb <= 1'b0;
            mix_cnt  <= '0;
        end else begin
            if (empty) adubou <= 1'b0;
            if (state_nxt != SPRAY) begin
                Mist_Adb <= 1'b0;
                mix_cnt  <= '0;
            end else if (state == SPRAY && b_rise && !adubou) begin
                Mist_Adb <= 1'b1;
                adubou   <= 1'b1;
                mix_cnt  <= '0;
            end else if (Mist_Adb && tick) begin
                if (mix_cnt == MIX_LAST) begin
                    Mist_Adb <= 1'b0;
                    mix_cnt  <= '0;
                end else begin
                    mix_cnt <= mix_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rega_multizona.sv
// Directed bench for rega_multizona with a fast prescaler (CLK_DIV=4).
module tb_rega_multizona;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] zone_req = '0;
    logic [7:0] zone_mode = '0;
    logic       B_Adb = 1'b0;
    logic       Ve, ERRO, Gotejamento, Aspersao, Limpeza, Mist_Adb, busy;
    logic [3:0] zone_active;
    logic [2:0] nivel;

    int checks = 0;
    int errors = 0;

    rega_multizona #(
        .LEVEL_W(3), .ZONES(4), .CLK_DIV(4), .FILL_TICKS(1), .DRIP_TICKS(4),
        .SPRAY_TICKS(2), .CLEAN_TICKS(1), .MIX_TICKS(3)
    ) dut (
        .clk(clk), .reset(reset), .zone_req(zone_req), .zone_mode(zone_mode),
        .B_Adb(B_Adb), .Ve(Ve), .ERRO(ERRO), .Gotejamento(Gotejamento),
        .Aspersao(Aspersao), .Limpeza(Limpeza), .Mist_Adb(Mist_Adb),
        .zone_active(zone_active), .nivel(nivel), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int bound, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < bound) begin
            cyc();
            n++;
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_nivel_change(input int bound, output int n, output bit ok);
        logic [2:0] old;
        old = nivel;
        n   = 0;
        ok  = 1'b0;
        while (n < bound) begin
            cyc();
            n++;
            if (nivel !== old) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset_fill(output bit ok);
        int n;
        reset = 1'b1;
        zone_req = '0;
        zone_mode = '0;
        B_Adb = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        wait_ready(100, n, ok);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc(); cyc();
        checks++; if (nivel !== 3'd0) begin errors++; $display("FAIL reset_nivel got=%0d exp=0", nivel); end
        checks++; if ({Ve, ERRO, Gotejamento, Aspersao, Limpeza, Mist_Adb, busy} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000000", {Ve, ERRO, Gotejamento, Aspersao, Limpeza, Mist_Adb, busy}); end
        checks++; if (zone_active !== 4'b0) begin errors++; $display("FAIL reset_zone_active got=%b exp=0000", zone_active); end
        reset = 1'b0;
        cyc();
        checks++; if ({Ve, busy} !== 2'b11) begin errors++; $display("FAIL idle_to_fill got Ve,busy=%b exp=11", {Ve, busy}); end
        checks++; if (nivel !== 3'd0) begin errors++; $display("FAIL fill_start_nivel got=%0d exp=0", nivel); end
    endtask

    task automatic test_fill();
        int n;
        bit ok;
        for (int k = 1; k <= 7; k++) begin
            wait_nivel_change(20, n, ok);
            checks++; if (!ok || nivel !== 3'(k)) begin errors++; $display("FAIL fill_level got=%0d exp=%0d", nivel, k); end
            checks++; if (n !== ((k == 1) ? 3 : 4)) begin errors++; $display("FAIL fill_interval got=%0d exp=%0d", n, (k == 1) ? 3 : 4); end
        end
        checks++; if ({busy, Ve} !== 2'b00) begin errors++; $display("FAIL fill_ready got busy,Ve=%b exp=00", {busy, Ve}); end
    endtask

    task automatic test_drip();
        int n;
        bit ok;
        zone_req  = 4'b0100;
        zone_mode = 8'b00_01_00_00;
        cyc();
        checks++; if (zone_active !== 4'b0100) begin errors++; $display("FAIL drip_zone got=%b exp=0100", zone_active); end
        checks++; if ({Gotejamento, Aspersao, Ve, busy} !== 4'b1001) begin
            errors++; $display("FAIL drip_flags got=%b exp=1001", {Gotejamento, Aspersao, Ve, busy}); end
        zone_mode = 8'b00_10_00_00;
        for (int k = 6; k >= 0; k--) begin
            wait_nivel_change(40, n, ok);
            checks++; if (!ok || nivel !== 3'(k)) begin errors++; $display("FAIL drip_level got=%0d exp=%0d", nivel, k); end
            checks++; if (n !== ((k == 6) ? 15 : 16)) begin errors++; $display("FAIL drip_interval got=%0d exp=%0d", n, (k == 6) ? 15 : 16); end
            if (k == 6) begin
                checks++; if ({Gotejamento, Aspersao} !== 2'b10) begin errors++; $display("FAIL drip_mode_ignored got=%b exp=10", {Gotejamento, Aspersao}); end
            end
        end
        checks++; if ({Ve, Gotejamento, zone_active} !== 6'b10_0000) begin
            errors++; $display("FAIL drip_empty_fill got=%b exp=100000", {Ve, Gotejamento, zone_active}); end
        zone_req = '0;
        wait_ready(60, n, ok);
        checks++; if (!ok || n !== 28 || nivel !== 3'd7) begin errors++; $display("FAIL refill got n=%0d nivel=%0d exp n=28 nivel=7", n, nivel); end
    endtask

    task automatic test_round_robin_fert();
        int n, high_cnt, rises;
        bit ok, prev, saw;
        do_reset_fill(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_initial_fill got=timeout exp=ready"); end
        zone_req  = 4'b1001;
        zone_mode = 8'b10_00_00_10;
        cyc();
        checks++; if ({zone_active, Aspersao, Gotejamento} !== 6'b0001_10) begin
            errors++; $display("FAIL rr_grant1 got=%b exp=000110", {zone_active, Aspersao, Gotejamento}); end
        high_cnt = 0; rises = 0; prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            B_Adb = (i < 4) || (i >= 20 && i < 24);
            cyc();
            if (Mist_Adb === 1'b1) high_cnt++;
            if (Mist_Adb === 1'b1 && !prev) rises++;
            prev = (Mist_Adb === 1'b1);
        end
        B_Adb = 1'b0;
        checks++; if (high_cnt !== 12) begin errors++; $display("FAIL mist_width got=%0d exp=12", high_cnt); end
        checks++; if (rises !== 1) begin errors++; $display("FAIL mist_second_press got rises=%0d exp=1", rises); end
        wait_ready(150, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_ready2 got=timeout exp=ready"); end
        cyc();
        checks++; if ({zone_active, Aspersao} !== 5'b1000_1) begin errors++; $display("FAIL rr_grant2 got=%b exp=10001", {zone_active, Aspersao}); end
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            B_Adb = (i < 4);
            cyc();
            if (Mist_Adb === 1'b1 && !prev) rises++;
            prev = (Mist_Adb === 1'b1);
        end
        B_Adb = 1'b0;
        checks++; if (rises !== 1) begin errors++; $display("FAIL mist_after_empty got rises=%0d exp=1", rises); end
        wait_ready(150, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_ready3 got=timeout exp=ready"); end
        cyc();
        checks++; if ({zone_active, Aspersao} !== 5'b0001_1) begin errors++; $display("FAIL rr_grant3 got=%b exp=00011", {zone_active, Aspersao}); end
        B_Adb = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10 && !saw; i++) begin
            cyc();
            if (Mist_Adb === 1'b1) saw = 1'b1;
        end
        checks++; if (!saw) begin errors++; $display("FAIL mist_third got=0 exp=1"); end
        zone_req = '0;
        B_Adb = 1'b0;
        cyc();
        checks++; if ({Limpeza, Mist_Adb, Aspersao, zone_active} !== 7'b100_0000) begin
            errors++; $display("FAIL spray_leave got=%b exp=1000000", {Limpeza, Mist_Adb, Aspersao, zone_active}); end
        wait_ready(120, n, ok);
        checks++; if (!ok || nivel !== 3'd7) begin errors++; $display("FAIL clean_refill got nivel=%0d exp=7", nivel); end
    endtask

    task automatic test_clean();
        int n;
        bit ok;
        zone_req  = 4'b0010;
        zone_mode = 8'b00_00_01_00;
        cyc();
        checks++; if ({zone_active, Gotejamento} !== 5'b0010_1) begin errors++; $display("FAIL clean_grant got=%b exp=00101", {zone_active, Gotejamento}); end
        wait_nivel_change(40, n, ok);
        wait_nivel_change(40, n, ok);
        checks++; if (!ok || nivel !== 3'd5) begin errors++; $display("FAIL clean_pre_level got=%0d exp=5", nivel); end
        zone_req = '0;
        cyc();
        checks++; if ({Limpeza, Gotejamento, zone_active, nivel} !== {2'b10, 4'b0000, 3'd5}) begin
            errors++; $display("FAIL clean_enter got L=%b G=%b za=%b nivel=%0d exp L=1 G=0 za=0000 nivel=5", Limpeza, Gotejamento, zone_active, nivel); end
        for (int k = 4; k >= 0; k--) begin
            wait_nivel_change(10, n, ok);
            checks++; if (!ok || nivel !== 3'(k)) begin errors++; $display("FAIL clean_level got=%0d exp=%0d", nivel, k); end
            if (k <= 3) begin
                checks++; if (n !== 4) begin errors++; $display("FAIL clean_interval got=%0d exp=4", n); end
            end
        end
        checks++; if ({Ve, Limpeza} !== 2'b10) begin errors++; $display("FAIL clean_to_fill got=%b exp=10", {Ve, Limpeza}); end
        wait_ready(60, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clean_ready got=timeout exp=ready"); end
    endtask

    task automatic test_err_and_reset();
        int bad;
        zone_req  = 4'b0100;
        zone_mode = 8'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mode_none_no_grant got=%0d busy cycles exp=0", bad); end
        zone_req  = 4'b0001;
        zone_mode = 8'b00_00_00_11;
        cyc();
        checks++; if ({ERRO, zone_active, busy} !== 6'b1_0001_1) begin errors++; $display("FAIL err_enter got=%b exp=100011", {ERRO, zone_active, busy}); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (nivel !== 3'd7 || ERRO !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL err_hold got=%0d bad cycles exp=0", bad); end
        zone_mode = 8'b00_00_00_01;
        cyc();
        checks++; if ({ERRO, busy, zone_active} !== 6'b0) begin errors++; $display("FAIL err_exit got=%b exp=000000", {ERRO, busy, zone_active}); end
        cyc();
        checks++; if ({Gotejamento, zone_active} !== 5'b1_0001) begin errors++; $display("FAIL err_regrant got=%b exp=10001", {Gotejamento, zone_active}); end
        for (int i = 0; i < 20; i++) cyc();
        reset = 1'b1;
        cyc();
        checks++; if ({nivel, Gotejamento, busy, Ve, zone_active} !== 10'b0) begin
            errors++; $display("FAIL midrun_reset got nivel=%0d G=%b busy=%b Ve=%b za=%b exp all 0", nivel, Gotejamento, busy, Ve, zone_active); end
        reset = 1'b0;
        zone_req = '0;
        cyc();
        checks++; if (Ve !== 1'b1) begin errors++; $display("FAIL post_reset_fill got Ve=%b exp=1", Ve); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drip();
        test_round_robin_fert();
        test_clean();
        test_err_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
